// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the dmem_responder slice: FSM state encoding,
// wait-counter width and the byte-lane merge used on stores.
package dmem_resp_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    // Widest supported data word; narrower words are zero-extended on the way in.
    localparam int unsigned MaxXlen  = 512;
    localparam int unsigned MaxLanes = MaxXlen / 8;

    typedef logic [MaxXlen-1:0]  word_t;
    typedef logic [MaxLanes-1:0] mask_t;

    function automatic word_t byte_merge(word_t old_word, word_t new_word, mask_t mask);
        word_t merged;
        merged = old_word;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (mask[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_resp_sram.sv
// Single-port scratch array, DEPTH_WORDS x XLEN, with combinational read and
// synchronous byte-lane-masked write.
module dmem_resp_sram
    import dmem_resp_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN/8-1:0] wmask,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= XLEN'(byte_merge(word_t'(mem[idx]), word_t'(wdata), mask_t'(wmask)));
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's dmem_* request/ready interface with configurable wait states.
// Optional saturating completion counters are enabled by defining DMEM_RESPONDER_STATS_EN.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     DEPTH_WORDS = 4096,
    parameter int unsigned     WAIT_STATES = 0,
    parameter longint unsigned BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wmask,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              dmem_ready,
`ifdef DMEM_RESPONDER_STATS_EN
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs,
`endif
    output logic              dmem_err
);

    localparam int unsigned           Lanes    = XLEN / 8;
    localparam int unsigned           LaneBits = $clog2(Lanes);
    localparam int unsigned           IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0]       Base     = XLEN'(BASE_ADDR);
    localparam logic [XLEN-1:0]       Depth    = XLEN'(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WaitInit = WAIT_CNT_W'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  accept;

    logic                  we_q;
    logic [XLEN-1:0]       addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [Lanes-1:0]      wmask_q;

    logic [XLEN:0]         off_ext;
    logic [XLEN-1:0]       word_off;
    logic                  in_range;
    logic                  sram_we;
    logic [XLEN-1:0]       sram_rdata;

    // The extra top bit is the borrow, i.e. addr below BASE_ADDR.
    assign off_ext  = {1'b0, addr_q} - {1'b0, Base};
    assign word_off = off_ext[XLEN-1:0] >> LaneBits;
    assign in_range = !off_ext[XLEN] && (word_off < Depth);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dmem_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                // Core withdrew the request: abandon it silently.
                if (!dmem_req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dmem_ready = 1'b0;
        dmem_err   = 1'b0;
        dmem_rdata = '0;
        if (state_q == StResp) begin
            dmem_ready = 1'b1;
            dmem_err   = !in_range;
            if (in_range && !we_q) dmem_rdata = sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            we_q    <= dmem_we;
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wdata;
            wmask_q <= dmem_wmask;
        end
    end

    // Reset in the RESP cycle must still drop the pending store.
    assign sram_we = rst_n && (state_q == StResp) && we_q && in_range;

    dmem_resp_sram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .idx   (word_off[IdxW-1:0]),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (sram_rdata)
    );

`ifdef DMEM_RESPONDER_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (dmem_ready) begin
            if (we_q) begin
                if (stores_q != '1) stores_q <= stores_q + 32'd1;
            end else if (loads_q != '1) begin
                loads_q <= loads_q + 32'd1;
            end
            if (dmem_err && (errs_q != '1)) errs_q <= errs_q + 32'd1;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule
